// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation encodings and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus {N, V, C, Z} flags from a, b and op.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             overflow;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;
  assign shamt   = b[SHW-1:0];

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff;
        carry    = (a >= b);
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = overflow;
    flags[FLAG_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU: S1 holds the accepted operands, S2 holds the computed result and flags.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic             s1_advance;
  logic             s2_advance;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  // Backpressure flows from the output: in_ready never looks at in_valid.
  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance && !rst;
  assign out_valid  = s2_valid;

  alu_core #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .result(core_result),
    .flags (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s2_valid <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else begin
      if (s1_advance) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= a;
          s1_b  <= b;
          s1_op <= op;
        end
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= core_result;
          flags  <= core_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (WIDTH=8): queue-based reference model plus directed checks.
module tb_pipelined_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_ready = 1'b0;

  logic [11:0] exp_q[$];
  bit          prev_hold = 1'b0;
  logic [7:0]  held_result;
  logic [3:0]  held_flags;

  pipelined_alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {N,V,C,Z, result}.
  function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
    int ua, ub, sa, sb, full, r;
    bit c, v;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    case (mop)
      3'd0: begin full = ua + ub; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin full = ua - ub; c = (ua >= ub);   v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: full = ua << (ub % 8);
      3'd6: full = ua >> (ub % 8);
      default: full = (sa < sb) ? 1 : 0;
    endcase
    r = full & 255;
    return {r >= 128, v, c, r == 0, 8'(r)};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: at each negedge, handshakes reflect what the coming edge will do.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", 16'(out_valid), 16'd1);
        checkOutput("hold_result", 16'(result), 16'(held_result));
        checkOutput("hold_flags", 16'(flags), 16'(held_flags));
      end
      if (out_valid) begin
        checkOutput("no_stale", 16'(exp_q.size() != 0), 16'd1);
        if (out_ready && exp_q.size() != 0) begin
          logic [11:0] e;
          e = exp_q.pop_front();
          checkOutput("stream_result", 16'(result), 16'(e[7:0]));
          checkOutput("stream_flags", 16'(flags), 16'(e[11:8]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
      prev_hold   = out_valid && !out_ready;
      held_result = result;
      held_flags  = flags;
    end
  end

  task automatic applyStimulus(input logic [7:0] sa, input logic [7:0] sb, input logic [2:0] sop);
    bit got;
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    a        = sa;
    b        = sb;
    op       = sop;
    forever begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
      waited++;
      if (waited > 100) begin
        checkOutput("accept_timeout", 16'd0, 16'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_result", 16'(result), 16'd0);
    checkOutput("reset_flags", 16'(flags), 16'd0);
    checkOutput("reset_in_ready", 16'(in_ready), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 16'(in_ready), 16'd1);

    // Hand-computed pins on the model itself.
    checkOutput("model_add", 16'(model(8'hF0, 8'h20, 3'd0)), 16'h210);
    checkOutput("model_sub_ovf", 16'(model(8'h80, 8'h01, 3'd1)), 16'h67F);
    checkOutput("model_sub_zero", 16'(model(8'h05, 8'h05, 3'd1)), 16'h300);
    checkOutput("model_slt", 16'(model(8'h80, 8'h01, 3'd7)), 16'h001);
    checkOutput("model_sll", 16'(model(8'h81, 8'h09, 3'd5)), 16'h002);
    checkOutput("model_srl", 16'(model(8'h81, 8'h0A, 3'd6)), 16'h020);

    // Latency: accepted at one edge, presented after the next.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hF0;
    b         = 8'h20;
    op        = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("lat_not_yet", 16'(out_valid), 16'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", 16'(out_valid), 16'd1);
    checkOutput("add_result", 16'(result), 16'h10);
    checkOutput("add_flags", 16'(flags), 16'h2);

    // Directed op coverage streamed back to back.
    applyStimulus(8'h80, 8'h01, 3'd1);
    applyStimulus(8'h05, 8'h05, 3'd1);
    applyStimulus(8'h80, 8'h01, 3'd7);
    applyStimulus(8'h81, 8'h09, 3'd5);
    applyStimulus(8'h7F, 8'h01, 3'd0);
    applyStimulus(8'hFF, 8'h01, 3'd0);
    applyStimulus(8'hC3, 8'h5A, 3'd4);
    applyStimulus(8'h90, 8'h03, 3'd6);
    applyStimulus(8'h01, 8'h80, 3'd7);
    applyStimulus(8'h01, 8'h02, 3'd1);
    waitDrain();

    // Backpressure: two sets fill the pipe, the third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h12;
    b         = 8'h34;
    op        = 3'd2;
    @(negedge clk);
    checkOutput("bp_ready1", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    op = 3'd3;
    @(negedge clk);
    checkOutput("bp_ready2", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    a  = 8'hA5;
    b  = 8'h0F;
    op = 3'd4;
    @(negedge clk);
    checkOutput("bp_full_in_ready", 16'(in_ready), 16'd0);
    checkOutput("bp_head_valid", 16'(out_valid), 16'd1);
    checkOutput("bp_head_result", 16'(result), 16'h10);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_still_full", 16'(in_ready), 16'd0);
    checkOutput("bp_still_head", 16'(result), 16'h10);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrain();

    // Random stream with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      idleCycles(int'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    waitDrain();

    // Reset with two sets in flight: nothing may emerge afterwards.
    out_ready = 1'b0;
    applyStimulus(8'h11, 8'h22, 3'd0);
    applyStimulus(8'h33, 8'h44, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_flush_valid", 16'(out_valid), 16'd0);
    out_ready = 1'b1;
    idleCycles(5);
    checkOutput("rst_no_emerge", 16'(out_valid), 16'd0);
    applyStimulus(8'h40, 8'h40, 3'd0);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
